switch_entry_capture: RTL and testbench

Parametrised successor to the single-player switch input stage of the Simon Says datapath. It synchronises and debounces the slide-switch bank, then decodes one completed press-and-release into a binary channel code. Each result is presented to the comparator with a valid/ready handshake and flags for multi-switch entries and inactivity timeouts. It sits between the board switches/LEDs and the sequence comparator.

---
 rtl/switch_entry_capture.sv | 203 ++++++++++++++++++++
 tb/tb_switch_entry_capture.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_entry_capture.sv
// Slide-switch entry stage: synchronise, debounce and decode one press-and-release
// into a channel code, presented to the comparator over a valid/ready handshake.
//
// state        | meaning
// -------------+------------------------------------------------------------
// IDLE         | game inactive, everything cleared
// WAIT_PRESS   | no switch set; inactivity timer running
// DB_PRESS     | candidate press captured, waiting for it to stay stable
// WAIT_RELEASE | press qualified, collecting extra switches until all clear
// DB_RELEASE   | all switches clear, waiting for the release to stay stable
// PRESENT      | result on the outputs until the comparator accepts it
module switch_entry_capture #(
    parameter int N_SW            = 10,
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int TIMEOUT_CYCLES  = 0,
    parameter int CODE_W          = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              on_off,
    input  logic [N_SW-1:0]   sw,
    output logic [N_SW-1:0]   led,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_multi,
    output logic              out_timeout,
    output logic              busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        DB_PRESS,
        WAIT_RELEASE,
        DB_RELEASE,
        PRESENT
    } state_t;

    state_t            state, state_nxt;
    logic [N_CH-1:0]   sync1, ssw;
    logic [N_CH-1:0]   cap, cap_nxt;
    logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic              valid_nxt, multi_nxt, timeout_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic              ch_zero;

    function automatic logic [CODE_W-1:0] lowest_index(input logic [N_CH-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

    // led is a raw pass-through; only the game channels need synchronising
    assign led     = sw;
    assign ch_zero = (ssw == '0);
    assign busy    = (state == DB_PRESS) || (state == WAIT_RELEASE) || (state == DB_RELEASE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            ssw   <= '0;
        end else begin
            sync1 <= sw[N_CH-1:0];
            ssw   <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cap         <= '0;
            db_cnt      <= '0;
            to_cnt      <= '0;
            out_valid   <= 1'b0;
            out_code    <= '0;
            out_multi   <= 1'b0;
            out_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cap         <= cap_nxt;
            db_cnt      <= db_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            out_valid   <= valid_nxt;
            out_code    <= code_nxt;
            out_multi   <= multi_nxt;
            out_timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cap_nxt     = cap;
        db_cnt_nxt  = db_cnt;
        to_cnt_nxt  = to_cnt;
        valid_nxt   = out_valid;
        code_nxt    = out_code;
        multi_nxt   = out_multi;
        timeout_nxt = out_timeout;

        if (!on_off) begin
            // leaving the game discards any pending result
            state_nxt   = IDLE;
            cap_nxt     = '0;
            db_cnt_nxt  = '0;
            to_cnt_nxt  = '0;
            valid_nxt   = 1'b0;
            code_nxt    = '0;
            multi_nxt   = 1'b0;
            timeout_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt  = WAIT_PRESS;
                    to_cnt_nxt = '0;
                end

                WAIT_PRESS: begin
                    if (!ch_zero) begin
                        cap_nxt    = ssw;
                        db_cnt_nxt = '0;
                        state_nxt  = DB_PRESS;
                    end else if ((TIMEOUT_CYCLES > 0) && (to_cnt == TO_MAX)) begin
                        state_nxt   = PRESENT;
                        valid_nxt   = 1'b1;
                        code_nxt    = '0;
                        multi_nxt   = 1'b0;
                        timeout_nxt = 1'b1;
                    end else if (to_cnt != TO_MAX) begin
                        to_cnt_nxt = to_cnt + TO_W'(1);
                    end
                end

                DB_PRESS: begin
                    // a bounce back to zero keeps the inactivity timer where it was
                    if (ch_zero) begin
                        state_nxt = WAIT_PRESS;
                    end else if (ssw != cap) begin
                        cap_nxt    = ssw;
                        db_cnt_nxt = '0;
                    end else if (db_cnt == DB_MAX) begin
                        state_nxt = WAIT_RELEASE;
                    end else begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                    end
                end

                WAIT_RELEASE: begin
                    if (ch_zero) begin
                        db_cnt_nxt = '0;
                        state_nxt  = DB_RELEASE;
                    end else begin
                        cap_nxt = cap | ssw;
                    end
                end

                DB_RELEASE: begin
                    if (!ch_zero) begin
                        cap_nxt    = cap | ssw;
                        db_cnt_nxt = '0;
                        state_nxt  = WAIT_RELEASE;
                    end else if (db_cnt == DB_MAX) begin
                        state_nxt   = PRESENT;
                        valid_nxt   = 1'b1;
                        code_nxt    = lowest_index(cap);
                        multi_nxt   = |(cap & (cap - N_CH'(1)));
                        timeout_nxt = 1'b0;
                    end else begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                    end
                end

                PRESENT: begin
                    // out_code is deliberately left holding the last result
                    if (out_valid && out_ready) begin
                        valid_nxt   = 1'b0;
                        multi_nxt   = 1'b0;
                        timeout_nxt = 1'b0;
                        cap_nxt     = '0;
                        db_cnt_nxt  = '0;
                        to_cnt_nxt  = '0;
                        state_nxt   = WAIT_PRESS;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_entry_capture.sv
// Bench for switch_entry_capture: expected results are queued as presses are
// driven and compared when the comparator side accepts a result.
module tb_switch_entry_capture;

    localparam int N_SW   = 10;
    localparam int CODE_W = 2;

    logic              clk = 1'b0;
    logic              reset, on_off, on_off_t, out_ready;
    logic [N_SW-1:0]   sw, led, led_t;
    logic              out_valid, out_multi, out_timeout, busy;
    logic [CODE_W-1:0] out_code;
    logic              out_valid_t, out_multi_t, out_timeout_t, busy_t;
    logic [CODE_W-1:0] out_code_t;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] code;
        logic       multi;
        logic       tmo;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;

    always #5 clk = ~clk;

    switch_entry_capture #(
        .N_SW(N_SW), .N_CH(4), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(0)
    ) dut (
        .clk(clk), .reset(reset), .on_off(on_off), .sw(sw), .led(led),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_multi(out_multi), .out_timeout(out_timeout), .busy(busy)
    );

    switch_entry_capture #(
        .N_SW(N_SW), .N_CH(4), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16)
    ) dut_t (
        .clk(clk), .reset(reset), .on_off(on_off_t), .sw(sw), .led(led_t),
        .out_valid(out_valid_t), .out_ready(1'b1), .out_code(out_code_t),
        .out_multi(out_multi_t), .out_timeout(out_timeout_t), .busy(busy_t)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // scoreboard: compare on every accepted handshake
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk_val("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk_val("sb_code", 32'(out_code), 32'(mon_e.code));
                chk_val("sb_multi", 32'(out_multi), 32'(mon_e.multi));
                chk_val("sb_timeout", 32'(out_timeout), 32'(mon_e.tmo));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        chk_val(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (!out_valid && n < max) begin
            tick(1);
            n++;
        end
        chk_val(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic press(input logic [N_SW-1:0] pat, input int hold, input int code, input logic multi);
        sw = pat;
        tick(hold);
        chk_val("led_follow", 32'(led), 32'(pat));
        exp_q.push_back({2'(code), multi, 1'b0});
        sw = '0;
        drain("press_result");
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b0;
        on_off    = 1'b0;
        on_off_t  = 1'b0;
        sw        = '0;
        out_ready = 1'b1;
        #22;
        chk_val("rst_valid", 32'(out_valid), 32'd0);
        chk_val("rst_code", 32'(out_code), 32'd0);
        chk_val("rst_multi", 32'(out_multi), 32'd0);
        chk_val("rst_timeout", 32'(out_timeout), 32'd0);
        chk_val("rst_busy", 32'(busy), 32'd0);
        on_off = 1'b1;
        reset  = 1'b1;
        tick(3);

        // single press, exact release-to-valid latency
        sw = 10'h004;
        tick(10);
        exp_q.push_back({2'd2, 1'b0, 1'b0});
        sw = '0;
        tick(7);
        chk_val("t1_early", 32'(out_valid), 32'd0);
        tick(1);
        chk_val("t1_latency", 32'(out_valid), 32'd1);
        tick(1);
        chk_val("t1_drop", 32'(out_valid), 32'd0);
        chk_val("t1_code_kept", 32'(out_code), 32'd2);
        chk_val("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        tick(2);

        // every channel, with noise on the led-only upper bits
        for (int c = 0; c < 4; c++) begin
            press({6'b101101, 4'(1 << c)}, 12, c, 1'b0);
        end

        // bouncing input then a stable hold gives exactly one result
        for (int k = 0; k < 6; k++) begin
            sw = (k % 2 == 0) ? 10'h001 : 10'h000;
            tick(2);
        end
        sw = 10'h001;
        tick(8);
        chk_val("t2_busy_hold", 32'(busy), 32'd1);
        exp_q.push_back({2'd0, 1'b0, 1'b0});
        sw = '0;
        drain("t2_result");
        tick(20);
        chk_val("t2_single", 32'(out_valid), 32'd0);

        // extra switch added while waiting for release
        sw = 10'h002;
        tick(8);
        sw = 10'h00A;
        tick(4);
        exp_q.push_back({2'd1, 1'b1, 1'b0});
        sw = '0;
        drain("t3_result");
        tick(2);
        press(10'h009, 12, 0, 1'b1);

        // backpressure: result held while switches move
        out_ready = 1'b0;
        sw = 10'h004;
        tick(10);
        sw = '0;
        wait_valid("t4_valid", 20);
        exp_q.push_back({2'd2, 1'b0, 1'b0});
        for (int k = 0; k < 20; k++) begin
            sw = (k < 16) ? 10'(k % 15 + 1) : 10'h000;
            tick(1);
            chk_val("t4_hold_valid", 32'(out_valid), 32'd1);
            chk_val("t4_hold_code", 32'(out_code), 32'd2);
            chk_val("t4_hold_multi", 32'(out_multi), 32'd0);
            chk_val("t4_hold_timeout", 32'(out_timeout), 32'd0);
        end
        out_ready = 1'b1;
        tick(1);
        chk_val("t4_accept", 32'(out_valid), 32'd0);
        chk_val("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        tick(20);
        chk_val("t4_no_new", 32'(out_valid), 32'd0);
        press(10'h008, 12, 3, 1'b0);

        // timeout instance, and no timeout on the disabled instance
        on_off_t = 1'b1;
        tick(16);
        chk_val("t5_not_early", 32'(out_valid_t), 32'd0);
        n = 0;
        while (!out_valid_t && n < 6) begin
            tick(1);
            n++;
        end
        chk_val("t5_valid", 32'(out_valid_t), 32'd1);
        chk_val("t5_timeout", 32'(out_timeout_t), 32'd1);
        chk_val("t5_code", 32'(out_code_t), 32'd0);
        chk_val("t5_multi", 32'(out_multi_t), 32'd0);
        chk_val("t5_led", 32'(led_t), 32'(sw));
        on_off_t = 1'b0;
        tick(1000);
        chk_val("t5_no_timeout", 32'(out_valid), 32'd0);

        // on_off dropped during release debounce
        sw = 10'h004;
        tick(10);
        sw = '0;
        tick(4);
        chk_val("t6_busy_dbrel", 32'(busy), 32'd1);
        on_off = 1'b0;
        tick(1);
        chk_val("t6a_busy", 32'(busy), 32'd0);
        chk_val("t6a_valid", 32'(out_valid), 32'd0);
        chk_val("t6a_code", 32'(out_code), 32'd0);
        on_off = 1'b1;
        tick(20);
        chk_val("t6a_discard", 32'(out_valid), 32'd0);

        // on_off dropped while a result waits
        out_ready = 1'b0;
        sw = 10'h002;
        tick(10);
        sw = '0;
        wait_valid("t6b_valid", 20);
        chk_val("t6b_code_pre", 32'(out_code), 32'd1);
        on_off = 1'b0;
        tick(1);
        chk_val("t6b_valid_off", 32'(out_valid), 32'd0);
        chk_val("t6b_code_off", 32'(out_code), 32'd0);
        on_off    = 1'b1;
        out_ready = 1'b1;
        tick(20);
        chk_val("t6b_discard", 32'(out_valid), 32'd0);

        // asynchronous reset mid-press
        sw = 10'h004;
        tick(5);
        chk_val("t6c_busy_pre", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk_val("t6c_busy_rst", 32'(busy), 32'd0);
        chk_val("t6c_led_rst", 32'(led), 32'(sw));
        #1 reset = 1'b1;
        tick(3);

        // asynchronous reset while a result waits
        out_ready = 1'b0;
        tick(10);
        sw = '0;
        wait_valid("t6d_valid", 30);
        chk_val("t6d_code_pre", 32'(out_code), 32'd2);
        sw = 10'h3FF;
        #2 reset = 1'b0;
        #1;
        chk_val("t6d_valid_rst", 32'(out_valid), 32'd0);
        chk_val("t6d_code_rst", 32'(out_code), 32'd0);
        chk_val("t6d_multi_rst", 32'(out_multi), 32'd0);
        chk_val("t6d_led_rst", 32'(led), 32'(sw));
        #1 reset = 1'b1;
        sw = '0;
        out_ready = 1'b1;
        tick(20);
        chk_val("t6d_idle", 32'(out_valid), 32'd0);

        chk_val("sb_final_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
